// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types for the FIR MAC sequencer: FSM state encoding and drain-length helpers.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  // Wide enough for the longest drain (RD_LAT + MAC_LAT = 6)
  localparam int unsigned DRAIN_CW = 3;

  function automatic int unsigned drain_cycles(input int unsigned rd_lat,
                                               input int unsigned mac_lat);
    return rd_lat + mac_lat;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-source / memory-control bundle of the FIR MAC sequencer.
// master = sample source + datapath side, slave = the sequencer.
interface fir_mac_sequencer_if #(
  parameter int unsigned NTAPS  = 16,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned AW = $clog2(NTAPS);

  logic              sample;
  logic [DATA_W-1:0] xIn;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              y_strobe;
  logic              busy;
  logic              overrun;

  modport master (
    output sample, xIn,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, coef_addr,
    input  mac_clr, mac_en, y_strobe, busy, overrun
  );

  modport slave (
    input  sample, xIn,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, coef_addr,
    output mac_clr, mac_en, y_strobe, busy, overrun
  );

endinterface

// File: rtl/fir_mac_sequencer_ctrl_delay.sv
// Parameterised 1-bit shift register with synchronous reset; aligns read strobes to MAC operands.
module fir_ctrl_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR: writes each sample into a circular delay line,
// then walks all taps driving RAM/ROM addresses and MAC controls, and flags the finished output.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int unsigned NTAPS   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  fir_mac_sequencer_if.slave bus
);

  localparam int unsigned AW        = $clog2(NTAPS);
  localparam int unsigned DRAIN_LEN = drain_cycles(RD_LAT, MAC_LAT);
  localparam logic [AW-1:0]       K_LAST  = AW'(NTAPS - 1);
  localparam logic [DRAIN_CW-1:0] DR_LAST = DRAIN_CW'(DRAIN_LEN - 1);

  seq_state_e          state_q, state_d;
  logic [AW-1:0]       k_q, k_d;
  logic [AW-1:0]       wp_q, wp_d;
  logic [DRAIN_CW-1:0] dr_q, dr_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic                overrun_q, overrun_d;
  logic                rd_en_s, first_tap_s, mac_en_s, mac_clr_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      k_q       <= '0;
      wp_q      <= '0;
      dr_q      <= '0;
      x_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wp_q      <= wp_d;
      dr_q      <= dr_d;
      x_q       <= x_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wp_d          = wp_q;
    dr_d          = dr_q;
    x_d           = x_q;
    overrun_d     = overrun_q | (bus.sample & (state_q != IDLE));
    rd_en_s       = 1'b0;
    first_tap_s   = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_addr   = '0;
    bus.coef_addr = '0;
    bus.y_strobe  = 1'b0;
    bus.busy      = (state_q != IDLE);
    bus.mac_en    = 1'b0;
    bus.mac_clr   = 1'b0;
    bus.overrun   = 1'b0;

    case (state_q)
      CLEAR: begin
        // k wraps to 0 on the last clear write, ready for the first RUN
        bus.wr_en   = 1'b1;
        bus.wr_addr = k_q;
        k_d         = k_q + 1'b1;
        if (k_q == K_LAST) state_d = IDLE;
        else               state_d = CLEAR;
      end
      IDLE: begin
        if (bus.sample) begin
          x_d     = bus.xIn;
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = wp_q;
        bus.wr_data = x_q;
        k_d         = '0;
        state_d     = RUN;
      end
      RUN: begin
        rd_en_s       = 1'b1;
        first_tap_s   = (k_q == '0);
        bus.rd_addr   = wp_q - k_q;
        bus.coef_addr = k_q;
        k_d           = k_q + 1'b1;
        dr_d          = '0;
        if (k_q == K_LAST) state_d = DRAIN;
        else               state_d = RUN;
      end
      DRAIN: begin
        dr_d = dr_q + 1'b1;
        if (dr_q == DR_LAST) state_d = DONE;
        else                 state_d = DRAIN;
      end
      DONE: begin
        bus.y_strobe = 1'b1;
        wp_d         = wp_q + 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // Outputs read as zero for every cycle reset is held
    if (reset) begin
      rd_en_s       = 1'b0;
      first_tap_s   = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.rd_addr   = '0;
      bus.coef_addr = '0;
      bus.wr_data   = '0;
      bus.y_strobe  = 1'b0;
      bus.busy      = 1'b0;
    end else begin
      bus.mac_en  = mac_en_s;
      bus.mac_clr = mac_clr_s;
      bus.overrun = overrun_q;
    end
    bus.rd_en = rd_en_s;
  end

  fir_ctrl_delay #(.DEPTH(RD_LAT)) u_mac_en_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (rd_en_s),
    .q_o   (mac_en_s)
  );

  fir_ctrl_delay #(.DEPTH(RD_LAT)) u_mac_clr_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (first_tap_s),
    .q_o   (mac_clr_s)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a behavioural delay-line RAM, coefficient ROM and MAC.
module tb_fir_mac_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fir_mac_sequencer_if #(.NTAPS(16), .DATA_W(16)) bus ();

  fir_mac_sequencer #(.NTAPS(16), .DATA_W(16), .RD_LAT(1), .MAC_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] ram [16];
  logic signed [15:0] rom [16];
  logic signed [15:0] rd_data;
  logic signed [15:0] coef_data;
  logic signed [39:0] acc;

  // Datapath model: 1-cycle RAM/ROM reads, 1-cycle MAC
  always @(posedge clk) begin
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    if (bus.rd_en) begin
      rd_data   <= ram[bus.rd_addr];
      coef_data <= rom[bus.coef_addr];
    end
    if (bus.mac_en) acc <= (bus.mac_clr ? 40'sd0 : acc) + rd_data * coef_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ovr);
    for (int i = 0; i < n; i++) begin
      total++;
      if ({bus.busy, bus.wr_en, bus.rd_en, bus.mac_en, bus.y_strobe} !== 5'b0 || bus.overrun !== ovr) begin
        bad++;
        $display("FAIL idle i=%0d got busy/wr/rd/mac/y=%b ovr=%b want 00000 ovr=%b",
                 i, {bus.busy, bus.wr_en, bus.rd_en, bus.mac_en, bus.y_strobe}, bus.overrun, ovr);
      end
      step();
    end
  endtask

  // One sample sequence from cycle 0 (sample strobe) through cycle 20 (y_strobe); ends at cycle 21
  task automatic run_sample(input logic [3:0] wp, input logic [15:0] x, input bit ovr_in,
                            input int inj_a, input int inj_b);
    bus.sample = 1'b1;
    bus.xIn    = x;
    step();
    bus.sample = 1'b0;
    bus.xIn    = 16'h0000;
    for (int c = 1; c <= 20; c++) begin
      logic        e_wr, e_rd, e_mac, e_clr, e_y, e_ovr;
      logic [3:0]  e_wa, e_ra, e_ca;
      logic [15:0] e_wd;
      e_wr  = (c == 1);
      e_wa  = e_wr ? wp : 4'd0;
      e_wd  = e_wr ? x : 16'h0000;
      e_rd  = (c >= 2 && c <= 17);
      e_ra  = e_rd ? wp - 4'(c - 2) : 4'd0;
      e_ca  = e_rd ? 4'(c - 2) : 4'd0;
      e_mac = (c >= 3 && c <= 18);
      e_clr = (c == 3);
      e_y   = (c == 20);
      e_ovr = ovr_in || (inj_a > 0 && c > inj_a) || (inj_b > 0 && c > inj_b);
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {e_wr, e_wa, e_wd}) begin
        bad++;
        $display("FAIL wr_port c=%0d got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                 c, bus.wr_en, bus.wr_addr, bus.wr_data, e_wr, e_wa, e_wd);
      end
      total++;
      if ({bus.rd_en, bus.rd_addr, bus.coef_addr} !== {e_rd, e_ra, e_ca}) begin
        bad++;
        $display("FAIL rd_port c=%0d got en=%b rd=%0d coef=%0d want en=%b rd=%0d coef=%0d",
                 c, bus.rd_en, bus.rd_addr, bus.coef_addr, e_rd, e_ra, e_ca);
      end
      total++;
      if ({bus.mac_en, bus.mac_clr} !== {e_mac, e_clr}) begin
        bad++;
        $display("FAIL mac_ctl c=%0d got en=%b clr=%b want en=%b clr=%b",
                 c, bus.mac_en, bus.mac_clr, e_mac, e_clr);
      end
      total++;
      if ({bus.y_strobe, bus.busy, bus.overrun} !== {e_y, 1'b1, e_ovr}) begin
        bad++;
        $display("FAIL status c=%0d got y=%b busy=%b ovr=%b want y=%b busy=1 ovr=%b",
                 c, bus.y_strobe, bus.busy, bus.overrun, e_y, e_ovr);
      end
      bus.sample = (c == inj_a || c == inj_b);
      bus.xIn    = bus.sample ? 16'hBEEF : 16'h0000;
      step();
    end
    bus.sample = 1'b0;
    bus.xIn    = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++;
    if ({bus.wr_en, bus.rd_en, bus.mac_en, bus.mac_clr, bus.y_strobe, bus.busy, bus.overrun} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs got %b want 0000000",
               {bus.wr_en, bus.rd_en, bus.mac_en, bus.mac_clr, bus.y_strobe, bus.busy, bus.overrun});
    end
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.rd_en} !== {1'b1, 4'(i), 16'h0000, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL clear i=%0d got wr=%b addr=%0d data=%h busy=%b rd=%b want wr=1 addr=%0d data=0000 busy=1 rd=0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.rd_en, i);
      end
      step();
    end
    total++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_en, bus.rd_addr, bus.coef_addr,
         bus.mac_en, bus.mac_clr, bus.y_strobe, bus.busy, bus.overrun} !== 39'b0) begin
      bad++;
      $display("FAIL post_clear got wr=%b rd=%b mac=%b y=%b busy=%b ovr=%b want all 0",
               bus.wr_en, bus.rd_en, bus.mac_en, bus.y_strobe, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_single();
    run_sample(4'd0, 16'h1234, 1'b0, -1, -1);
    idle(12, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 16; i++) begin
      run_sample(4'(i), 16'(i * 16'h0111), 1'b0, -1, -1);
      idle(12, 1'b0);
    end
  endtask

  task automatic test_overrun();
    run_sample(4'd1, 16'hCAFE, 1'b0, 10, 20);
    run_sample(4'd2, 16'h5555, 1'b1, -1, -1);
    idle(12, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    bus.sample = 1'b1;
    bus.xIn    = 16'h0F0F;
    step();
    bus.sample = 1'b0;
    bus.xIn    = 16'h0000;
    for (int c = 1; c < 8; c++) step();
    reset = 1'b1;
    #1;
    total++;
    if ({bus.wr_en, bus.rd_en, bus.mac_en, bus.busy, bus.overrun} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_hold got wr/rd/mac/busy/ovr=%b want 00000",
               {bus.wr_en, bus.rd_en, bus.mac_en, bus.busy, bus.overrun});
    end
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.rd_en, bus.mac_en, bus.overrun, bus.wr_en, bus.wr_addr, bus.busy} !== {3'b000, 1'b1, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset_next got rd=%b mac=%b ovr=%b wr=%b addr=%0d busy=%b want rd=0 mac=0 ovr=0 wr=1 addr=0 busy=1",
               bus.rd_en, bus.mac_en, bus.overrun, bus.wr_en, bus.wr_addr, bus.busy);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'(i), 16'h0000}) begin
        bad++;
        $display("FAIL reclear i=%0d got wr=%b addr=%0d data=%h want wr=1 addr=%0d data=0000",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, i);
      end
      step();
    end
    idle(1, 1'b0);
    run_sample(4'd0, 16'h0A0A, 1'b0, -1, -1);
    idle(12, 1'b0);
  endtask

  task automatic test_end_to_end();
    logic signed [15:0] hist [16];
    logic [15:0]        x;
    longint             g;
    int                 cnt;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) step();
    for (int h = 0; h < 16; h++) hist[h] = 16'sd0;
    for (int n = 0; n < 1024; n++) begin
      x = 16'($urandom);
      for (int h = 15; h > 0; h--) hist[h] = hist[h-1];
      hist[0] = x;
      g = 0;
      for (int k = 0; k < 16; k++) g += longint'(rom[k]) * longint'(hist[k]);
      bus.sample = 1'b1;
      bus.xIn    = x;
      step();
      bus.sample = 1'b0;
      bus.xIn    = 16'h0000;
      cnt = 1;
      while (bus.y_strobe !== 1'b1 && cnt < 40) begin
        step();
        cnt++;
      end
      total++;
      if (cnt != 20) begin
        bad++;
        $display("FAIL e2e_latency n=%0d got %0d cycles want 20", n, cnt);
      end
      total++;
      if (longint'(acc) !== g) begin
        bad++;
        $display("FAIL e2e_y n=%0d got %0d want %0d", n, longint'(acc), g);
      end
      while (cnt < 33) begin
        step();
        cnt++;
      end
    end
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL e2e_overrun got %b want 0", bus.overrun);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.sample = 1'b0;
    bus.xIn    = 16'h0000;
    for (int i = 0; i < 16; i++) rom[i] = 16'(i * 3001) ^ 16'hA55A;
    test_reset();
    test_single();
    test_wrap();
    test_overrun();
    test_reset_mid_run();
    test_end_to_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
